sdram_resp: RTL and testbench



---
 rtl/sdram_resp_if.sv | 17 +
 rtl/sdram_resp.sv | 253 +++++++++++++++++++++++++
 tb/tb_sdram_resp.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_resp_if.sv
// SDRAM command, address and byte-mask pins shared by the controller (master)
// and the sdram_resp device model (slave).
interface sdram_resp_if;
  logic        sdram_ce;
  logic        sdram_cs;
  logic        sdram_ras;
  logic        sdram_cas;
  logic        sdram_we;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_a;
  logic [1:0]  sdram_dqm;

  modport master (output sdram_ce, sdram_cs, sdram_ras, sdram_cas, sdram_we,
                  sdram_ba, sdram_a, sdram_dqm);
  modport slave  (input  sdram_ce, sdram_cs, sdram_ras, sdram_cas, sdram_we,
                  sdram_ba, sdram_a, sdram_dqm);
endinterface

// File: rtl/sdram_resp.sv
// Cycle-accurate SDR SDRAM device responder (16-bit, 4 banks, CL2/3, BL1-8).
// Optional timing checker: define SDRAM_RESP_TIMING_CHECK_EN.
module sdram_resp #(
  parameter int unsigned ROW_BITS = 10,
  parameter int unsigned COL_BITS = 9,
  parameter int unsigned T_RCD    = 2,
  parameter int unsigned T_RP     = 2,
  parameter int unsigned T_RFC    = 7
) (
  input  logic        clk,
  input  logic        rst,
  sdram_resp_if.slave bus,
  inout  wire  [15:0] sdram_dq,
  output logic        err
);
  localparam int unsigned ADDR_W = 2 + ROW_BITS + COL_BITS;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

  logic [15:0] mem [DEPTH];

  logic is_act, is_rd, is_wr, is_pre, is_ref, is_lmr, is_bst;
  logic [1:0]          ba;
  logic [ROW_BITS-1:0] cmd_row;
  logic [COL_BITS-1:0] cmd_col;
  logic                ap;
  logic                rd_go, wr_go;

  state_t              state;
  logic [3:0]          bank_open;
  logic [ROW_BITS-1:0] bank_row [4];
  logic [1:0]          bl_log;
  logic                cl3;
  logic                wr_single;
  logic [1:0]          b_bank;
  logic [ROW_BITS-1:0] b_row;
  logic [COL_BITS-1:0] b_col;
  logic [2:0]          b_beat, b_last, cur_last;
  logic                b_ap;
  logic                s1_valid, dq_en;
  logic [15:0]         s1_data, dq_out;
  logic                timing_bad;

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_idx, rd_idx;
  logic                fetch_valid;
  logic [15:0]         fetch;

  // Column of a burst beat: wraps inside the BL-aligned block.
  function automatic logic [COL_BITS-1:0] beat_col(input logic [COL_BITS-1:0] start,
                                                   input logic [2:0] beat,
                                                   input logic [2:0] last);
    logic [COL_BITS-1:0] mask;
    mask = COL_BITS'(last);
    return (start & ~mask) | ((start + COL_BITS'(beat)) & mask);
  endfunction

  always_comb begin
    is_act = 1'b0; is_rd = 1'b0; is_wr = 1'b0; is_pre = 1'b0;
    is_ref = 1'b0; is_lmr = 1'b0; is_bst = 1'b0;
    if (bus.sdram_ce && !bus.sdram_cs) begin
      case ({bus.sdram_ras, bus.sdram_cas, bus.sdram_we})
        3'b011:  is_act = 1'b1;
        3'b101:  is_rd  = 1'b1;
        3'b100:  is_wr  = 1'b1;
        3'b010:  is_pre = 1'b1;
        3'b001:  is_ref = 1'b1;
        3'b000:  is_lmr = 1'b1;
        3'b110:  is_bst = 1'b1;
        default: ;
      endcase
    end
  end

  assign ba       = bus.sdram_ba;
  assign cmd_row  = bus.sdram_a[ROW_BITS-1:0];
  assign cmd_col  = bus.sdram_a[COL_BITS-1:0];
  assign ap       = bus.sdram_a[10];
  assign rd_go    = is_rd && bank_open[ba];
  assign wr_go    = is_wr && bank_open[ba];
  assign cur_last = 3'((4'd1 << bl_log) - 4'd1);

  // Beat 0 of a write lands on the command edge; later beats come from the engine.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    if (wr_go) begin
      wr_en  = 1'b1;
      wr_idx = {ba, bank_row[ba], cmd_col};
    end else if (bus.sdram_ce && state == WR_BURST && !rd_go && !is_bst) begin
      wr_en  = 1'b1;
      wr_idx = {b_bank, b_row, beat_col(b_col, b_beat, b_last)};
    end
  end

  assign rd_idx      = {b_bank, b_row, beat_col(b_col, b_beat, b_last)};
  assign fetch_valid = (state == RD_BURST);
  assign fetch       = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      if (!bus.sdram_dqm[1]) mem[wr_idx][15:8] <= sdram_dq[15:8];
      if (!bus.sdram_dqm[0]) mem[wr_idx][7:0]  <= sdram_dq[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bank_open <= '0;
      for (int i = 0; i < 4; i++) bank_row[i] <= '0;
      bl_log    <= '0;
      cl3       <= 1'b1;
      wr_single <= 1'b0;
      err       <= 1'b0;
      b_bank    <= '0;
      b_row     <= '0;
      b_col     <= '0;
      b_beat    <= '0;
      b_last    <= '0;
      b_ap      <= 1'b0;
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      dq_en     <= 1'b0;
      dq_out    <= '0;
    end else if (bus.sdram_ce) begin
      // Read data pipeline: one extra stage when CL=3; a WRITE flushes it.
      if (wr_go) begin
        s1_valid <= 1'b0;
        dq_en    <= 1'b0;
      end else if (cl3) begin
        dq_en    <= s1_valid;
        dq_out   <= s1_data;
        s1_valid <= fetch_valid;
        s1_data  <= fetch;
      end else begin
        dq_en    <= fetch_valid;
        dq_out   <= fetch;
        s1_valid <= 1'b0;
      end

      if (state != IDLE) begin
        if (b_beat == b_last) begin
          state <= IDLE;
          if (b_ap) bank_open[b_bank] <= 1'b0;
        end else begin
          b_beat <= b_beat + 3'd1;
        end
      end

      if (is_lmr) begin
        wr_single <= bus.sdram_a[9];
        if (bus.sdram_a[2:0] <= 3'd3) bl_log <= bus.sdram_a[1:0];
        else begin
          bl_log <= '0;
          err    <= 1'b1;
        end
        if (bus.sdram_a[3]) err <= 1'b1;
        if (bus.sdram_a[6:4] == 3'd2)      cl3 <= 1'b0;
        else if (bus.sdram_a[6:4] == 3'd3) cl3 <= 1'b1;
        else begin
          cl3 <= 1'b1;
          err <= 1'b1;
        end
      end
      if (is_act) begin
        bank_open[ba] <= 1'b1;
        bank_row[ba]  <= cmd_row;
      end
      if (is_pre) begin
        if (ap) bank_open <= '0;
        else    bank_open[ba] <= 1'b0;
      end
      if (is_bst) state <= IDLE;
      if ((is_rd || is_wr) && !bank_open[ba]) err <= 1'b1;
      if (timing_bad) err <= 1'b1;

      if (rd_go || wr_go) begin
        b_bank <= ba;
        b_row  <= bank_row[ba];
        b_col  <= cmd_col;
        b_last <= cur_last;
        b_ap   <= ap;
      end
      if (rd_go) begin
        state  <= RD_BURST;
        b_beat <= '0;
      end
      if (wr_go) begin
        if (wr_single || bl_log == 2'd0) begin
          state <= IDLE;
          if (ap) bank_open[ba] <= 1'b0;
        end else begin
          state  <= WR_BURST;
          b_beat <= 3'd1;
        end
      end
    end
  end

  assign sdram_dq = dq_en ? dq_out : {16{1'bz}};

  logic unused_addr;
  assign unused_addr = ^bus.sdram_a[12:11];

`ifdef SDRAM_RESP_TIMING_CHECK_EN
  localparam int unsigned TW = 8;
  logic [TW-1:0] rcd_cnt [4];
  logic [TW-1:0] rp_cnt  [4];
  logic [TW-1:0] rfc_cnt;
  logic          any_cmd;

  assign any_cmd = is_act | is_rd | is_wr | is_pre | is_ref | is_lmr | is_bst;

  always_comb begin
    timing_bad = 1'b0;
    if ((is_rd || is_wr) && rcd_cnt[ba] != '0) timing_bad = 1'b1;
    if (is_act && rp_cnt[ba] != '0)            timing_bad = 1'b1;
    if (any_cmd && rfc_cnt != '0)              timing_bad = 1'b1;
    if (is_ref && bank_open != '0)             timing_bad = 1'b1;
  end

  // Counters hold the remaining wait; zero means the command is legal.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        rcd_cnt[i] <= '0;
        rp_cnt[i]  <= '0;
      end
      rfc_cnt <= '0;
    end else if (bus.sdram_ce) begin
      for (int i = 0; i < 4; i++) begin
        if (rcd_cnt[i] != '0) rcd_cnt[i] <= rcd_cnt[i] - TW'(1);
        if (rp_cnt[i] != '0)  rp_cnt[i]  <= rp_cnt[i] - TW'(1);
      end
      if (rfc_cnt != '0) rfc_cnt <= rfc_cnt - TW'(1);
      if (is_act) rcd_cnt[ba] <= TW'(T_RCD - 1);
      if (is_pre) begin
        if (ap) for (int i = 0; i < 4; i++) rp_cnt[i] <= TW'(T_RP - 1);
        else    rp_cnt[ba] <= TW'(T_RP - 1);
      end
      if (is_ref) rfc_cnt <= TW'(T_RFC - 1);
    end
  end
`else
  assign timing_bad = 1'b0;

  logic unused_timing;
  assign unused_timing = ^{is_ref, 32'(T_RCD), 32'(T_RP), 32'(T_RFC)};
`endif

endmodule

// File: tb/tb_sdram_resp.sv
// Directed bench for sdram_resp: expected read beats are queued with the cycle
// they must appear on dq and checked every cycle; err is checked at key points.
module tb_sdram_resp;
  localparam logic [3:0]  C_ACT   = 4'b0011;
  localparam logic [3:0]  C_RD    = 4'b0101;
  localparam logic [3:0]  C_WR    = 4'b0100;
  localparam logic [3:0]  C_LMR   = 4'b0000;
  localparam logic [15:0] DQ_IDLE = 16'hFFFF;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic err;
  logic        dq_oe;
  logic [15:0] dq_drv;
  tri1  [15:0] sdram_dq;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   t, t2;
  logic err_timing;

  sdram_resp_if bif ();

  sdram_resp dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bif),
    .sdram_dq (sdram_dq),
    .err      (err)
  );

  assign sdram_dq = dq_oe ? dq_drv : {16{1'bz}};

  always #5 clk = ~clk;

  task automatic check_dq();
    exp_t e;
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      total++;
      assert (sdram_dq === e.data)
        else begin bad++; $error("FAIL dq_beat cyc=%0d got=%h exp=%h", cyc, sdram_dq, e.data); end
    end else if (!dq_oe) begin
      total++;
      assert (sdram_dq === DQ_IDLE)
        else begin bad++; $error("FAIL dq_released cyc=%0d got=%h exp=%h", cyc, sdram_dq, DQ_IDLE); end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_dq();
  endtask

  task automatic nop(input int n);
    repeat (n) tick();
  endtask

  task automatic check_err(input logic expv, input string tag);
    total++;
    assert (err === expv)
      else begin bad++; $error("FAIL err_%s cyc=%0d got=%b exp=%b", tag, cyc, err, expv); end
  endtask

  task automatic cmd(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
    {bif.sdram_cs, bif.sdram_ras, bif.sdram_cas, bif.sdram_we} = c;
    bif.sdram_ba = b;
    bif.sdram_a  = a;
    tick();
    {bif.sdram_cs, bif.sdram_ras, bif.sdram_cas, bif.sdram_we} = 4'b1111;
  endtask

  task automatic wr(input logic [1:0] b, input logic [12:0] col, input logic [15:0] base,
                    input logic [15:0] step, input int n, input logic [1:0] dqm);
    dq_oe = 1'b1;
    bif.sdram_dqm = dqm;
    for (int k = 0; k < n; k++) begin
      dq_drv = base + 16'(k) * step;
      if (k == 0) cmd(C_WR, b, col);
      else        tick();
    end
    dq_oe = 1'b0;
    bif.sdram_dqm = 2'b00;
  endtask

  task automatic push(input int c, input logic [15:0] d);
    exp_t e;
    e.cyc  = c;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
`ifdef SDRAM_RESP_TIMING_CHECK_EN
    err_timing = 1'b1;
`else
    err_timing = 1'b0;
`endif
    rst = 1'b1;
    dq_oe = 1'b0;
    dq_drv = '0;
    bif.sdram_ce = 1'b1;
    {bif.sdram_cs, bif.sdram_ras, bif.sdram_cas, bif.sdram_we} = 4'b1111;
    bif.sdram_ba = '0;
    bif.sdram_a = '0;
    bif.sdram_dqm = 2'b00;
    nop(3);
    check_err(1'b0, "reset");
    rst = 1'b0;

    // BL4 CL3 write at col 6 wraps in the 4-block; read from col 4
    cmd(C_LMR, 2'd0, 13'h032);
    nop(1);
    cmd(C_ACT, 2'd1, 13'd5);
    nop(1);
    wr(2'd1, 13'd6, 16'h1111, 16'h1111, 4, 2'b00);
    nop(2);
    cmd(C_RD, 2'd1, 13'd4);
    t = cyc;
    push(t + 2, 16'h3333);
    push(t + 3, 16'h4444);
    push(t + 4, 16'h1111);
    push(t + 5, 16'h2222);
    nop(6);
    check_err(1'b0, "bl4_read");

    // CL2 single-location write with upper byte masked
    cmd(C_LMR, 2'd0, 13'h220);
    nop(1);
    wr(2'd1, 13'd20, 16'h1234, 16'h0000, 1, 2'b00);
    nop(1);
    wr(2'd1, 13'd20, 16'hBEEF, 16'h0000, 1, 2'b10);
    nop(1);
    cmd(C_RD, 2'd1, 13'd20);
    t = cyc;
    push(t + 1, 16'h12EF);
    nop(3);
    check_err(1'b0, "cl2_mask");

    // BL8 read truncated by a second read two cycles later
    cmd(C_LMR, 2'd0, 13'h033);
    nop(1);
    wr(2'd1, 13'd0, 16'hA000, 16'h0001, 8, 2'b00);
    nop(1);
    wr(2'd1, 13'd8, 16'hB000, 16'h0001, 8, 2'b00);
    nop(2);
    cmd(C_RD, 2'd1, 13'd3);
    t = cyc;
    push(t + 2, 16'hA003);
    push(t + 3, 16'hA004);
    nop(1);
    cmd(C_RD, 2'd1, 13'd8);
    t2 = cyc;
    for (int k = 0; k < 8; k++) push(t2 + 2 + k, 16'hB000 + 16'(k));
    nop(12);
    check_err(1'b0, "truncate");

    // Read of a never-activated bank: no drive, sticky err
    cmd(C_RD, 2'd3, 13'd0);
    check_err(1'b1, "closed_bank");
    nop(4);
    check_err(1'b1, "closed_sticky");
    do_reset();
    check_err(1'b0, "after_rst");

    // Invalid CAS latency code
    cmd(C_LMR, 2'd0, 13'h012);
    check_err(1'b1, "bad_cl");
    do_reset();

    // READ one cycle after ACTIVE; contents survive rst
    cmd(C_LMR, 2'd0, 13'h032);
    nop(1);
    cmd(C_ACT, 2'd1, 13'd5);
    cmd(C_RD, 2'd1, 13'd8);
    t = cyc;
    for (int k = 0; k < 4; k++) push(t + 2 + k, 16'hB000 + 16'(k));
    check_err(err_timing, "trcd");
    nop(6);

    // rst during the second beat of a BL4 read
    do_reset();
    check_err(1'b0, "rst2");
    cmd(C_LMR, 2'd0, 13'h032);
    nop(1);
    cmd(C_ACT, 2'd1, 13'd5);
    nop(1);
    cmd(C_RD, 2'd1, 13'd12);
    t = cyc;
    push(t + 2, 16'hB004);
    push(t + 3, 16'hB005);
    nop(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_err(1'b0, "rst_mid");
    cmd(C_RD, 2'd1, 13'd12);
    check_err(1'b1, "rd_after_rst");
    nop(5);

    total++;
    assert (sb.size() === 0)
      else begin bad++; $error("FAIL sb_drained got=%0d exp=0", sb.size()); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
